// File: rtl/sd_emmc_pkg.sv
// Shared definitions for the SD/eMMC CMD-line blocks: FSM encoding, frame lengths
// and the serial CRC7 step used by both receive checking and transmit generation.
package sd_emmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_CHECK     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_TX_PRE    = 3'd4,
    ST_TX        = 3'd5
  } state_e;

  localparam int          CMD_LEN   = 48;
  localparam int          R2_LEN    = 136;
  localparam logic [6:0]  CRC7_POLY = 7'h09;

  // One bit of x^7 + x^3 + 1, MSB-first input order.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_emmc_crc7_serial.sv
// Serial CRC7 accumulator. clear and enable may be asserted together: the bit is
// then folded into a zeroed register, so a frame's first bit needs no extra cycle.
module sd_emmc_crc7_serial
  import sd_emmc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc_o
);

  logic [6:0] crc_reg;
  logic [6:0] crc_base;

  assign crc_base = clear ? 7'h00 : crc_reg;
  assign crc_o    = crc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= 7'h00;
    end else if (enable) begin
      crc_reg <= crc7_step(crc_base, bit_in);
    end else if (clear) begin
      crc_reg <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_emmc_cmd_device.sv
// Card-side CMD-line responder: receives 48-bit host commands, checks CRC7/end bit,
// and sends a 48-bit or 136-bit response with CRC7 generated on the fly.
module sd_emmc_cmd_device
  import sd_emmc_pkg::*;
#(
  parameter int NCR_MIN      = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_in,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_ok_o,
  input  logic         resp_start_i,
  input  logic         resp_long_i,
  input  logic [119:0] resp_i,
  output logic         busy_o,
  output logic         resp_done_o
);

  state_e        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [135:0]  sr_reg, sr_next;
  logic          long_reg, long_next;
  logic [5:0]    index_reg, index_next;
  logic [31:0]   arg_reg, arg_next;
  logic          crc_ok_reg, crc_ok_next;
  logic          valid_reg, valid_next;
  logic          done_reg, done_next;

  logic          rx_crc_clear, rx_crc_en;
  logic          tx_crc_clear, tx_crc_en;
  logic [6:0]    rx_crc, tx_crc;
  logic [7:0]    tx_len;
  logic [46:0]   rx_frame;
  logic [7:0]    crc_off;
  logic [2:0]    crc_sel;

  sd_emmc_crc7_serial u_rx_crc (
    .clk    (sd_clk),
    .rst    (rst),
    .clear  (rx_crc_clear),
    .enable (rx_crc_en),
    .bit_in (cmd_in),
    .crc_o  (rx_crc)
  );

  sd_emmc_crc7_serial u_tx_crc (
    .clk    (sd_clk),
    .rst    (rst),
    .clear  (tx_crc_clear),
    .enable (tx_crc_en),
    .bit_in (sr_reg[R2_LEN-1]),
    .crc_o  (tx_crc)
  );

  assign tx_len   = long_reg ? 8'(R2_LEN) : 8'(CMD_LEN);
  // Bits 46..0 of the incoming frame once the end bit is on the line.
  assign rx_frame = {sr_reg[45:0], cmd_in};

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 8'd0;
      sr_reg     <= '0;
      long_reg   <= 1'b0;
      index_reg  <= 6'd0;
      arg_reg    <= 32'd0;
      crc_ok_reg <= 1'b0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sr_reg     <= sr_next;
      long_reg   <= long_next;
      index_reg  <= index_next;
      arg_reg    <= arg_next;
      crc_ok_reg <= crc_ok_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sr_next      = sr_reg;
    long_next    = long_reg;
    index_next   = index_reg;
    arg_next     = arg_reg;
    crc_ok_next  = crc_ok_reg;
    valid_next   = 1'b0;
    done_next    = 1'b0;
    rx_crc_clear = 1'b0;
    rx_crc_en    = 1'b0;
    tx_crc_clear = 1'b0;
    tx_crc_en    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!cmd_in) begin
          state_next   = ST_RX;
          cnt_next     = 8'd0;
          rx_crc_clear = 1'b1;
          rx_crc_en    = 1'b1;
        end
      end

      ST_RX: begin
        sr_next   = {sr_reg[134:0], cmd_in};
        cnt_next  = cnt_reg + 8'd1;
        // Transmission bit through the last argument bit are covered.
        rx_crc_en = (cnt_reg <= 8'd38);
        if (cnt_reg == 8'd0 && !cmd_in) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 8'd46) begin
          state_next  = ST_CHECK;
          valid_next  = 1'b1;
          index_next  = rx_frame[45:40];
          arg_next    = rx_frame[39:8];
          crc_ok_next = (rx_crc == rx_frame[7:1]) && rx_frame[0];
        end
      end

      ST_CHECK: begin
        state_next = ST_WAIT_RESP;
        cnt_next   = 8'd0;
      end

      ST_WAIT_RESP: begin
        if (resp_start_i) begin
          state_next   = ST_TX_PRE;
          cnt_next     = 8'd0;
          long_next    = resp_long_i;
          tx_crc_clear = 1'b1;
          if (resp_long_i) begin
            sr_next = {2'b00, 6'b111111, resp_i, 8'h00};
          end else begin
            sr_next = {2'b00, resp_i[37:0], 96'd0};
          end
        end else if (!cmd_in) begin
          state_next   = ST_RX;
          cnt_next     = 8'd0;
          rx_crc_clear = 1'b1;
          rx_crc_en    = 1'b1;
        end else if (cnt_reg == 8'(RESP_TIMEOUT - 1)) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_TX_PRE: begin
        if (cnt_reg == 8'(NCR_MIN - 1)) begin
          state_next = ST_TX;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_TX: begin
        sr_next  = {sr_reg[134:0], 1'b0};
        cnt_next = cnt_reg + 8'd1;
        // Long frames exclude the start/transmission/reserved prefix from the CRC.
        if (long_reg) begin
          tx_crc_en = (cnt_reg >= 8'd8) && (cnt_reg <= 8'd127);
        end else begin
          tx_crc_en = (cnt_reg <= 8'd39);
        end
        if (cnt_reg == tx_len - 8'd1) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // The CRC register is final by the first CRC slot, so it is muxed onto the line.
  always_comb begin
    crc_off   = cnt_reg - (tx_len - 8'd8);
    crc_sel   = 3'(8'd6 - crc_off);
    cmd_out_o = 1'b1;
    if (state_reg == ST_TX) begin
      if (cnt_reg == tx_len - 8'd1) begin
        cmd_out_o = 1'b1;
      end else if (cnt_reg >= tx_len - 8'd8) begin
        cmd_out_o = tx_crc[crc_sel];
      end else begin
        cmd_out_o = sr_reg[R2_LEN-1];
      end
    end
  end

  assign cmd_oe_o     = (state_reg == ST_TX_PRE) || (state_reg == ST_TX);
  assign busy_o       = (state_reg != ST_IDLE);
  assign cmd_valid_o  = valid_reg;
  assign cmd_index_o  = index_reg;
  assign cmd_arg_o    = arg_reg;
  assign cmd_crc_ok_o = crc_ok_reg;
  assign resp_done_o  = done_reg;

endmodule

// File: tb/tb_sd_emmc_cmd_device.sv
// Scoreboard bench for sd_emmc_cmd_device: stimulus queues expected command decodes and
// response line images; a negedge monitor compares them as the DUT presents them.
module tb_sd_emmc_cmd_device;
  localparam int NCR = 2;
  localparam int TMO = 64;

  logic         sd_clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_in = 1'b1;
  logic         cmd_out_o, cmd_oe_o, cmd_valid_o, cmd_crc_ok_o, busy_o, resp_done_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_start_i = 1'b0;
  logic         resp_long_i = 1'b0;
  logic [119:0] resp_i = '0;

  typedef struct packed { logic [5:0] idx; logic [31:0] arg; logic ok; } cmd_exp_t;
  typedef struct packed { int len; logic [143:0] bits; logic aborted; } resp_exp_t;

  cmd_exp_t  cmd_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int passes = 0;

  logic [143:0] cap;
  int           ncap;
  logic         prev_oe = 1'b0;

  sd_emmc_cmd_device #(.NCR_MIN(NCR), .RESP_TIMEOUT(TMO)) dut (
    .sd_clk(sd_clk), .rst(rst), .cmd_in(cmd_in), .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o),
    .cmd_valid_o(cmd_valid_o), .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
    .cmd_crc_ok_o(cmd_crc_ok_o), .resp_start_i(resp_start_i), .resp_long_i(resp_long_i),
    .resp_i(resp_i), .busy_o(busy_o), .resp_done_o(resp_done_o)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] crc7_bits(input logic [135:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic exp_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ok);
    cmd_exp_t e;
    e.idx = idx; e.arg = arg; e.ok = ok;
    cmd_q.push_back(e);
  endtask

  task automatic exp_resp(input int len, input logic [143:0] bits, input logic aborted);
    resp_exp_t r;
    r.len = len; r.bits = bits; r.aborted = aborted;
    resp_q.push_back(r);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      cmd_in = f[i];
    end
    @(negedge sd_clk);
    cmd_in = 1'b1;
  endtask

  task automatic send_resp(input logic long_f, input logic [119:0] payload);
    @(negedge sd_clk);
    resp_start_i = 1'b1;
    resp_long_i  = long_f;
    resp_i       = payload;
    @(posedge sd_clk);
    #1;
    chk("oe_after_start", 144'(cmd_oe_o), 144'(1));
    chk("p_bit_level", 144'(cmd_out_o), 144'(1));
    @(negedge sd_clk);
    resp_start_i = 1'b0;
    resp_long_i  = 1'b0;
    resp_i       = '0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy_o && n < max) begin
      @(negedge sd_clk);
      n++;
    end
    chk("idle_in_time", 144'(busy_o), 144'(0));
  endtask

  // Monitor: command decodes and complete CMD-line drive windows.
  always @(negedge sd_clk) begin
    cmd_exp_t  e;
    resp_exp_t r;
    if (cmd_valid_o) begin
      if (cmd_q.size() == 0) begin
        chk("unexpected_cmd_valid", 144'(cmd_valid_o), 144'(0));
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_index", 144'(cmd_index_o), 144'(e.idx));
        chk("cmd_arg", 144'(cmd_arg_o), 144'(e.arg));
        chk("cmd_crc_ok", 144'(cmd_crc_ok_o), 144'(e.ok));
      end
    end
    if (cmd_oe_o) begin
      if (!prev_oe) begin
        cap  = '0;
        ncap = 0;
      end
      cap = {cap[142:0], cmd_out_o};
      ncap++;
    end else if (prev_oe) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp_len", 144'(ncap), 144'(0));
      end else begin
        r = resp_q.pop_front();
        if (r.aborted) begin
          chk("no_done_after_rst", 144'(resp_done_o), 144'(0));
        end else begin
          chk("resp_len", 144'(ncap), 144'(r.len + NCR));
          chk("resp_bits", cap, r.bits);
          chk("resp_done", 144'(resp_done_o), 144'(1));
        end
      end
    end else if (resp_done_o) begin
      chk("stray_done", 144'(resp_done_o), 144'(0));
    end
    prev_oe = cmd_oe_o;
  end

  initial begin
    logic [39:0]  s40;
    logic [47:0]  f48;
    logic [119:0] pl;

    repeat (3) @(posedge sd_clk);
    #1;
    chk("rst_out", 144'(cmd_out_o), 144'(1));
    chk("rst_oe", 144'(cmd_oe_o), 144'(0));
    chk("rst_valid", 144'(cmd_valid_o), 144'(0));
    chk("rst_crc_ok", 144'(cmd_crc_ok_o), 144'(0));
    chk("rst_busy", 144'(busy_o), 144'(0));
    chk("rst_done", 144'(resp_done_o), 144'(0));
    chk("rst_index", 144'(cmd_index_o), 144'(0));
    chk("rst_arg", 144'(cmd_arg_o), 144'(0));
    @(negedge sd_clk);
    rst = 1'b0;
    repeat (2) @(negedge sd_clk);

    // CMD0, never answered: times out after exactly TMO cycles in WAIT_RESP.
    exp_cmd(6'd0, 32'h0, 1'b1);
    send_frame(48'h400000000095);
    repeat (TMO) @(negedge sd_clk);
    chk("busy_before_timeout", 144'(busy_o), 144'(1));
    @(negedge sd_clk);
    chk("idle_after_timeout", 144'(busy_o), 144'(0));

    // CMD8 with R7 short response; upper resp_i bits must be ignored.
    exp_cmd(6'd8, 32'h000001AA, 1'b1);
    send_frame(48'h48000001AA87);
    repeat (3) @(negedge sd_clk);
    exp_resp(48, {94'h0, 2'b11, 48'h08000001AA13}, 1'b0);
    send_resp(1'b0, {82'h2AAAA, 6'h08, 32'h000001AA});
    wait_idle(400);

    // Corrupted CRC byte.
    exp_cmd(6'd8, 32'h000001AA, 1'b0);
    send_frame(48'h48000001AA89);
    wait_idle(200);

    // CMD55 with a short R1 response.
    exp_cmd(6'd55, 32'h0, 1'b1);
    send_frame(48'h770000000065);
    repeat (2) @(negedge sd_clk);
    s40 = {2'b00, 6'd55, 32'h00000120};
    f48 = {s40, crc7_bits({96'h0, s40}, 40), 1'b1};
    exp_resp(48, {94'h0, 2'b11, f48}, 1'b0);
    send_resp(1'b0, {82'h0, 6'd55, 32'h00000120});
    wait_idle(400);

    // Long R2 response of zeros.
    exp_cmd(6'd8, 32'h000001AA, 1'b1);
    send_frame(48'h48000001AA87);
    repeat (2) @(negedge sd_clk);
    exp_resp(136, {6'h0, 2'b11, 8'h3F, 120'h0, 8'h01}, 1'b0);
    send_resp(1'b1, 120'h0);
    wait_idle(400);

    // Long R2 response with a non-trivial payload.
    exp_cmd(6'd8, 32'h000001AA, 1'b1);
    send_frame(48'h48000001AA87);
    repeat (2) @(negedge sd_clk);
    pl = 120'hDEADBEEF0123456789ABCDEF0F1E2D;
    exp_resp(136, {6'h0, 2'b11, 8'h3F, pl, crc7_bits({16'h0, pl}, 120), 1'b1}, 1'b0);
    send_resp(1'b1, pl);
    wait_idle(400);

    // Transmission bit of 0: abort, nothing reported.
    @(negedge sd_clk); cmd_in = 1'b0;
    @(negedge sd_clk); cmd_in = 1'b0;
    @(negedge sd_clk); cmd_in = 1'b1;
    @(negedge sd_clk);
    chk("abort_to_idle", 144'(busy_o), 144'(0));
    repeat (50) @(negedge sd_clk);

    // New host command while waiting: first response dropped, second command decoded.
    exp_cmd(6'd8, 32'h000001AA, 1'b1);
    send_frame(48'h48000001AA87);
    repeat (5) @(negedge sd_clk);
    exp_cmd(6'd55, 32'h0, 1'b1);
    send_frame(48'h770000000065);
    wait_idle(200);

    // resp_start in IDLE is ignored.
    @(negedge sd_clk); resp_start_i = 1'b1;
    @(negedge sd_clk); resp_start_i = 1'b0;
    repeat (10) @(negedge sd_clk);
    chk("ignored_start_idle", 144'(busy_o), 144'(0));

    // Reset in the middle of a response.
    exp_cmd(6'd8, 32'h000001AA, 1'b1);
    send_frame(48'h48000001AA87);
    repeat (2) @(negedge sd_clk);
    exp_resp(48, '0, 1'b1);
    send_resp(1'b0, {82'h0, 6'h08, 32'h000001AA});
    repeat (20) @(negedge sd_clk);
    rst = 1'b1;
    @(posedge sd_clk);
    #1;
    chk("oe_after_rst", 144'(cmd_oe_o), 144'(0));
    chk("done_after_rst", 144'(resp_done_o), 144'(0));
    chk("index_after_rst", 144'(cmd_index_o), 144'(0));
    @(negedge sd_clk);
    rst = 1'b0;
    repeat (20) @(negedge sd_clk);
    chk("still_idle_after_rst", 144'(busy_o), 144'(0));

    chk("cmd_q_drained", 144'(cmd_q.size()), 144'(0));
    chk("resp_q_drained", 144'(resp_q.size()), 144'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sd_emmc_cmd_device.md
# sd_emmc_cmd_device

Device-side responder for the SD/eMMC CMD line: the card end of the protocol that `sd_emmc_cmd_serial_host` initiates. It deserializes 48-bit host commands, checks the CRC7 and end bit, and presents index and argument to a device model. It then serializes a 48-bit short (R1/R3/R6/R7) or 136-bit long (R2) response with a generated CRC7. It sits behind `sd_emmc_phy`, or direct in a loopback build, as a synthesizable eMMC card model for host bring-up.

## Interface
- `NCR_MIN`, 2: P-bit cycles (driven '1') between accepting `resp_start_i` and the response start bit; legal range 2..15.
- `RESP_TIMEOUT`, 64: cycles spent in WAIT_RESP before abandoning the response; legal range 8..255.

Ports. One clock; reset is synchronous and active-high.
- `sd_clk` in 1: sole clock; all sampling and driving on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_in` in 1: CMD line sample, already registered in `sd_clk` domain.
- `cmd_out_o` out 1: CMD line drive value.
- `cmd_oe_o` out 1: 1 = device drives CMD.
- `cmd_valid_o` out 1: one-cycle pulse; a command frame has been received.
- `cmd_index_o` out 6: command index; held until the next frame.
- `cmd_arg_o` out 32: command argument; held until the next frame.
- `cmd_crc_ok_o` out 1: CRC7 matched and end bit = 1; valid with `cmd_valid_o`.
- `resp_start_i` in 1: request to send a response; honoured only in WAIT_RESP.
- `resp_long_i` in 1: 0 = 48-bit frame, 1 = 136-bit frame; sampled with `resp_start_i`.
- `resp_i` in 120: payload, sampled with `resp_start_i`.
  - Short frame uses `[37:0]` = {index, arg}.
  - Long frame uses all 120 bits.
- `busy_o` out 1: high in every state except IDLE.
- `resp_done_o` out 1: one-cycle pulse after the response end bit has been driven.

## Operation
- States: IDLE, RX, CHECK, WAIT_RESP, TX_PRE, TX.
- IDLE:
  - `cmd_in`=0 → RX; the start bit is fed to CRC7 (init 7'h00).
- RX:
  - Shifts 47 further bits.
  - Bit 46 (transmission bit) = 0 → abort to IDLE; no `cmd_valid_o`.
  - Bits 45..8 are index/arg and are fed to CRC.
  - Bits 7..1 are received CRC. Bit 0 is the end bit.
  - After the end bit → CHECK.
- CHECK: one cycle.
  - Loads `cmd_index_o`/`cmd_arg_o`.
  - Pulses `cmd_valid_o`.
  - `cmd_crc_ok_o` = (computed CRC == received CRC) && end bit.
  - → WAIT_RESP, timeout counter cleared.
- WAIT_RESP:
  - `resp_start_i` → TX_PRE; frame shift register loaded.
  - Short frame: '0','0', `resp_i[37:0]`, CRC7, '1'.
  - Long frame: '0','0', 6'b111111, `resp_i[119:0]`, CRC7, '1'.
  - CRC7 covers the frame from the start bit for short frames, and only `resp_i[119:0]` for long frames.
  - Counter reaching `RESP_TIMEOUT` → IDLE silently (no-response commands, e.g. CMD0).
  - `cmd_in`=0 (new host start bit) → abandon the pending response, enter RX.
- TX_PRE: `NCR_MIN` cycles with `cmd_oe_o`=1, `cmd_out_o`=1, then → TX.
- TX:
  - Drives 48 or 136 bits MSB first; `cmd_in` is ignored.
  - After the end bit: `cmd_oe_o`=0, `resp_done_o` pulse, → IDLE.
- CRC7: polynomial x^7+x^3+1, serial, one bit per cycle.

## Timing
- Reset values:
  - `cmd_out_o`=1, `cmd_oe_o`=0.
  - `cmd_valid_o`, `cmd_crc_ok_o`, `busy_o`, `resp_done_o` = 0.
  - `cmd_index_o`=0, `cmd_arg_o`=0.
  - State IDLE.
- End bit sampled at edge n → `cmd_valid_o` high in cycle n+1.
- `resp_start_i` sampled at edge k:
  - `cmd_oe_o` high from k+1.
  - Start bit driven at k+1+`NCR_MIN`.
  - Last bit at k+`NCR_MIN`+L, where L = 48 or 136.
  - `cmd_oe_o` low and `resp_done_o` high at k+`NCR_MIN`+L+1.
- `resp_start_i` in the same cycle as timeout expiry → response wins.
- `resp_start_i` outside WAIT_RESP is ignored, with no latching.
- `rst` mid-TX → `cmd_oe_o`=0 on the next edge; no partial completion pulse.

## Structure
- Shared package `sd_emmc_pkg` holds:
  - state encoding;
  - `CMD_LEN`=48, `R2_LEN`=136;
  - `CRC7_POLY`=7'h09.
- One sub-module, `sd_emmc_crc7_serial`, instanced twice (RX check, TX generate).
  - Ports: clk, rst, clear, enable, bit_in, crc_o.
- Shift register: 136 bits. Bit counter: 8 bits.

## Test plan
- CMD0 frame 48'h400000000095 on `cmd_in`:
  - `cmd_valid_o`, index 0, arg 0, `cmd_crc_ok_o`=1.
  - No `resp_start_i` → IDLE after 64 cycles, `cmd_oe_o` never high.
- CMD8 frame 48'h48000001AA87:
  - index 8, arg 32'h000001AA, crc_ok=1.
  - `resp_start_i` with `resp_long_i`=0, `resp_i[37:0]`={6'h08,32'h000001AA} → line shows 2 P-bits, then 48'h08000001AA13, then `resp_done_o`.
- CMD8 frame with CRC byte corrupted to 8'h89 → `cmd_crc_ok_o`=0, `cmd_index_o`=8.
- Long response:
  - `resp_long_i`=1, `resp_i`=120'h0 → 136 bits = 8'h3F, 120 zeros, CRC7 7'h00, '1'; `cmd_oe_o` high for exactly 138 cycles.
- Frame with transmission bit 0 → no `cmd_valid_o`, back to IDLE.
- Boundary cases:
  - New host start bit in WAIT_RESP → previous response dropped, new command decoded.
  - `rst` during TX → `cmd_oe_o`=0 on the next edge.
